watchdog_heartbeat_tx: RTL and testbench
========================================

Name: watchdog_heartbeat_tx

Overview:
- Drive side of the shared watchdog line between Red Pitaya boards; pairs with the existing tristate pad/synchronizer block.
- When enabled as master, drives a periodic heartbeat square wave through that block's output-value and direction controls.
- Stops the heartbeat and releases the line if software stops kicking. Also releases it if the synchronized readback disagrees with the driven level, which indicates contention.
- Sits between the AXI config/status registers and the pad block.

Parameters:
- CNT_W, 32, width of the half_period, timeout and edge_count fields.
- SETTLE_CYCLES, 4, cycles after each driven edge before readback is compared. Must cover the 2-FF synchronizer plus pad delay.

Ports:
- clk  in  1  system clock; all logic is synchronous to it.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run heartbeat as master, 0 = release line.
- half_period  in  CNT_W  cycles per heartbeat half period.
- timeout  in  CNT_W  maximum number of cycles between kicks; 0 disables kick supervision.
- kick  in  1  single-cycle software alive pulse.
- fault_clr  in  1  single-cycle pulse; clears sticky fault states.
- line_in  in  1  synchronized readback from the pad block.
- line_out  out  1  value to drive; connects to the pad output-value input.
- line_dir  out  1  pad 3-state enable; 1 = input (released), 0 = output (driving).
- active  out  1  1 in RUN_HI or RUN_LO.
- expired  out  1  1 in EXPIRED.
- contention  out  1  1 in CONTENTION.
- edge_count  out  CNT_W  number of heartbeat edges driven since the last entry into IDLE; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release) values:
  - state = IDLE; line_out = 0; line_dir = 1; active = 0; expired = 0; contention = 0; edge_count = 0.
  - All internal counters = 0.
- All outputs are registered and decoded from the state.
- Effective half period hp_eff = max(half_period, SETTLE_CYCLES+1), sampled at every edge.
- States and outputs:
  - IDLE: dir = 1, out = 0.
  - RUN_HI: dir = 0, out = 1.
  - RUN_LO: dir = 0, out = 0.
  - EXPIRED: dir = 1, out = 0.
  - CONTENTION: dir = 1, out = 0.
- Transition priority per cycle, highest first:
  1. enable = 0 -> IDLE from any state; edge_count cleared.
  2. IDLE and enable = 1 -> RUN_HI on the next cycle. edge_count becomes 1, and the half-period, settle and timeout counters are cleared.
  3. In RUN_*: timeout != 0 and timeout counter == timeout-1 and kick = 0 -> EXPIRED.
     - A kick in the same cycle wins: the counter is cleared and the state does not change.
  4. In RUN_*: settle counter has reached SETTLE_CYCLES and line_in != line_out -> CONTENTION.
     - If expiry and contention occur in the same cycle, EXPIRED wins.
  5. In RUN_*: half-period counter == hp_eff-1 -> the other RUN state. The half-period counter is cleared, the settle counter is cleared, and edge_count is incremented.
  6. EXPIRED or CONTENTION with fault_clr = 1 -> IDLE. If enable is still 1, the next cycle goes to RUN_HI.
- Each RUN level lasts exactly hp_eff cycles; the first RUN_HI after IDLE is full length.
- Timeout counter behaviour:
  - Counts only in RUN_*.
  - Cleared by kick.
  - Saturates; it never wraps.
- Settle counter behaviour:
  - Counts 0..SETTLE_CYCLES after each edge, then holds.
  - Compare is active only while the counter is held at SETTLE_CYCLES.
- Other rules:
  - kick and fault_clr are ignored in IDLE.
  - Changing half_period mid-run takes effect at the next edge.
  - Reset asserted mid-run releases the line (dir = 1) immediately and asynchronously.

Test Plan:
- Normal run: reset, enable=1, half_period=10, timeout=0, line_in looped back through 2 FFs.
  - Required: line_out high 10 cycles, then low 10 cycles, repeating.
  - Required: line_dir=0 throughout; edge_count=6 after 60 cycles in RUN; contention stays 0.
- Expiry: half_period=8, timeout=50, with no kick.
  - Required: EXPIRED on cycle 50 after RUN_HI entry; line_dir=1, line_out=0, expired=1.
  - Then fault_clr -> IDLE, then RUN_HI.
  - Variant: kick in the same cycle as the expiry cycle -> stays in RUN and expired stays 0.
- Contention: force line_in=0 while line_out=1.
  - Required: contention=1 and line_dir=1 exactly SETTLE_CYCLES+1 cycles after the edge.
  - Same mismatch lasting only 3 cycles after the edge -> no fault.
- Clamp: half_period=1 with SETTLE_CYCLES=4.
  - Required: each level lasts 5 cycles.
- Priority and reset:
  - Drop enable during CONTENTION -> IDLE next cycle with edge_count=0.
  - Assert aresetn=0 mid RUN_LO -> line_dir=1 with no clock edge.

Source files
------------

// File: rtl/watchdog_heartbeat_tx.sv
// Heartbeat driver for the shared watchdog line. It toggles the pad while software keeps kicking,
// and it releases the line on a kick timeout or when the readback shows contention.
module watchdog_heartbeat_tx #(
  parameter int CNT_W         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic [CNT_W-1:0] half_period,
  input  logic [CNT_W-1:0] timeout,
  input  logic             kick,
  input  logic             fault_clr,
  input  logic             line_in,
  output logic             line_out,
  output logic             line_dir,
  output logic             active,
  output logic             expired,
  output logic             contention,
  output logic [CNT_W-1:0] edge_count,
  output logic [2:0]       fsm_state
);

  localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]    SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] HP_MIN     = CNT_W'(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RUN_HI     = 3'd1,
    S_RUN_LO     = 3'd2,
    S_EXPIRED    = 3'd3,
    S_CONTENTION = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] hp_cnt, hp_cnt_n;
  logic [CNT_W-1:0] hp_eff, hp_eff_n;
  logic [CNT_W-1:0] to_cnt, to_cnt_n;
  logic [SW-1:0]    settle_cnt, settle_cnt_n;
  logic [CNT_W-1:0] edge_count_n;
  logic [CNT_W-1:0] hp_sample;
  logic             settled;
  logic             timeout_hit;

  // A period shorter than the settle window could never be checked, so it is clamped.
  assign hp_sample   = (half_period < HP_MIN) ? HP_MIN : half_period;
  assign settled     = (settle_cnt == SETTLE_MAX);
  assign timeout_hit = (timeout != '0) && (to_cnt == timeout - ONE) && !kick;
  assign fsm_state   = state;

  always_comb begin
    state_n      = state;
    hp_cnt_n     = hp_cnt;
    hp_eff_n     = hp_eff;
    to_cnt_n     = to_cnt;
    settle_cnt_n = settle_cnt;
    edge_count_n = edge_count;
    if (!enable) begin
      state_n      = S_IDLE;
      hp_cnt_n     = '0;
      to_cnt_n     = '0;
      settle_cnt_n = '0;
      edge_count_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n      = S_RUN_HI;
          hp_cnt_n     = '0;
          to_cnt_n     = '0;
          settle_cnt_n = '0;
          hp_eff_n     = hp_sample;
          edge_count_n = ONE;
        end
        S_RUN_HI, S_RUN_LO: begin
          hp_cnt_n     = hp_cnt + ONE;
          settle_cnt_n = settled ? settle_cnt : settle_cnt + SW'(1);
          if (kick)           to_cnt_n = '0;
          else if (!(&to_cnt)) to_cnt_n = to_cnt + ONE;
          // Expiry outranks contention, which outranks the normal toggle.
          if (timeout_hit) begin
            state_n = S_EXPIRED;
          end else if (settled && (line_in != line_out)) begin
            state_n = S_CONTENTION;
          end else if (hp_cnt == hp_eff - ONE) begin
            state_n      = (state == S_RUN_HI) ? S_RUN_LO : S_RUN_HI;
            hp_cnt_n     = '0;
            settle_cnt_n = '0;
            hp_eff_n     = hp_sample;
            edge_count_n = edge_count + ONE;
          end
        end
        S_EXPIRED, S_CONTENTION: begin
          if (fault_clr) begin
            state_n      = S_IDLE;
            edge_count_n = '0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      hp_cnt     <= '0;
      hp_eff     <= '0;
      to_cnt     <= '0;
      settle_cnt <= '0;
      edge_count <= '0;
      line_out   <= 1'b0;
      line_dir   <= 1'b1;
      active     <= 1'b0;
      expired    <= 1'b0;
      contention <= 1'b0;
    end else begin
      state      <= state_n;
      hp_cnt     <= hp_cnt_n;
      hp_eff     <= hp_eff_n;
      to_cnt     <= to_cnt_n;
      settle_cnt <= settle_cnt_n;
      edge_count <= edge_count_n;
      line_out   <= (state_n == S_RUN_HI);
      line_dir   <= !((state_n == S_RUN_HI) || (state_n == S_RUN_LO));
      active     <= (state_n == S_RUN_HI) || (state_n == S_RUN_LO);
      expired    <= (state_n == S_EXPIRED);
      contention <= (state_n == S_CONTENTION);
    end
  end

endmodule

// File: tb/tb_watchdog_heartbeat_tx.sv
// Bench for watchdog_heartbeat_tx: directed scenarios queue cycle-tagged expected outputs,
// and a negedge monitor pops and compares them.
module tb_watchdog_heartbeat_tx;
  localparam int CNT_W  = 32;
  localparam int SETTLE = 4;
  localparam int W      = CNT_W + 5;

  // {line_out, line_dir, active, expired, contention}
  localparam logic [4:0] P_IDLE = 5'b01000;
  localparam logic [4:0] P_HI   = 5'b10100;
  localparam logic [4:0] P_LO   = 5'b00100;
  localparam logic [4:0] P_EXP  = 5'b01010;
  localparam logic [4:0] P_CON  = 5'b01001;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic enable = 1'b0;
  logic kick = 1'b0;
  logic fault_clr = 1'b0;
  logic [CNT_W-1:0] half_period = '0;
  logic [CNT_W-1:0] timeout = '0;
  logic line_in, line_out, line_dir, active, expired, contention;
  logic [CNT_W-1:0] edge_count;
  logic [2:0] fsm_state;

  logic sync1 = 1'b0, sync2 = 1'b0;
  logic force_en = 1'b0, force_val = 1'b0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  string        exp_name_q[$];

  watchdog_heartbeat_tx #(.CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .half_period(half_period),
    .timeout(timeout), .kick(kick), .fault_clr(fault_clr), .line_in(line_in),
    .line_out(line_out), .line_dir(line_dir), .active(active), .expired(expired),
    .contention(contention), .edge_count(edge_count), .fsm_state(fsm_state)
  );

  // Clock, cycle counter, and pad model: released line reads 0, then a 2-FF synchronizer.
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    sync1 <= line_dir ? 1'b0 : line_out;
    sync2 <= sync1;
  end
  assign line_in = force_en ? force_val : sync2;

  task automatic expect_at(input int c, input logic [4:0] p, input int ec, input string name);
    exp_cyc_q.push_back(c);
    exp_q.push_back({p, CNT_W'(ec)});
    exp_name_q.push_back(name);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_now(input string name, input logic [W-1:0] want);
    logic [W-1:0] got;
    got = {line_out, line_dir, active, expired, contention, edge_count};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  // Monitor: compare the head entry in the cycle it is tagged with.
  always @(negedge clk) begin
    logic [W-1:0] got, want;
    string nm;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      checks++;
      failures++;
      $display("FAIL %s stale expectation for cyc=%0d at cyc=%0d", exp_name_q[0], exp_cyc_q[0], cyc);
      void'(exp_cyc_q.pop_front());
      void'(exp_q.pop_front());
      void'(exp_name_q.pop_front());
    end
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      got  = {line_out, line_dir, active, expired, contention, edge_count};
      want = exp_q.pop_front();
      nm   = exp_name_q.pop_front();
      void'(exp_cyc_q.pop_front());
      checks++;
      if (got !== want)  begin
        failures++;
        $display("FAIL %s cyc=%0d got out/dir/act/exp/con=%b ec=%0d want %b ec=%0d",
                 nm, cyc, got[W-1:CNT_W], got[CNT_W-1:0], want[W-1:CNT_W], want[CNT_W-1:0]);
      end
    end
  end

  initial begin
    int e, e2, budget;
    // Reset
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;
    expect_at(cyc, P_IDLE, 0, "reset_state");
    expect_at(cyc + 1, P_IDLE, 0, "idle_hold");
    wait_cyc(cyc + 2);

    // Normal run: 10-cycle levels with loopback; edge count 1..6 across 60 cycles
    half_period = 10; timeout = 0; enable = 1'b1;
    e = cyc + 1;
    for (int k = 0; k < 60; k++)
      expect_at(e + k, ((k / 10) % 2 == 0) ? P_HI : P_LO, k / 10 + 1, "normal_run");
    expect_at(e + 60, P_IDLE, 0, "disable_to_idle");
    wait_cyc(e + 59);
    enable = 1'b0;
    wait_cyc(e + 60);

    // Expiry after 50 cycles, fault_clr back through IDLE, then kick at the expiry cycle
    half_period = 8; timeout = 50; enable = 1'b1;
    e  = cyc + 1;
    e2 = e + 57;
    expect_at(e + 49, P_HI, 7, "pre_expiry");
    expect_at(e + 50, P_EXP, 7, "expiry");
    expect_at(e + 55, P_EXP, 7, "expiry_hold");
    expect_at(e + 56, P_IDLE, 0, "fault_clr_idle");
    expect_at(e + 57, P_HI, 1, "restart_run_hi");
    expect_at(e2 + 49, P_HI, 7, "kick_cycle");
    expect_at(e2 + 50, P_HI, 7, "kick_saves");
    expect_at(e2 + 99, P_HI, 13, "kick_restarts_window");
    expect_at(e2 + 100, P_EXP, 13, "expiry_after_kick");
    expect_at(e2 + 102, P_IDLE, 0, "disable_from_expired");
    wait_cyc(e + 55);
    fault_clr = 1'b1;
    wait_cyc(e + 56);
    fault_clr = 1'b0;
    wait_cyc(e2 + 49);
    kick = 1'b1;
    wait_cyc(e2 + 50);
    kick = 1'b0;
    wait_cyc(e2 + 101);
    enable = 1'b0;
    wait_cyc(e2 + 102);

    // Contention: readback stuck low while driving high; then drop enable
    half_period = 10; timeout = 0; force_en = 1'b1; force_val = 1'b0; enable = 1'b1;
    e = cyc + 1;
    expect_at(e + 4, P_HI, 1, "settle_window");
    expect_at(e + 5, P_CON, 1, "contention");
    expect_at(e + 6, P_CON, 1, "contention_hold");
    expect_at(e + 7, P_IDLE, 0, "disable_from_contention");
    wait_cyc(e + 6);
    enable = 1'b0;
    wait_cyc(e + 7);
    force_en = 1'b0;

    // Mismatch confined to the settle window: no fault
    force_en = 1'b1; force_val = 1'b0; enable = 1'b1;
    e = cyc + 1;
    expect_at(e + 5, P_HI, 1, "short_mismatch_ok");
    expect_at(e + 9, P_HI, 1, "short_mismatch_hi_end");
    expect_at(e + 10, P_LO, 2, "short_mismatch_lo");
    expect_at(e + 15, P_LO, 2, "short_mismatch_lo_mid");
    expect_at(e + 16, P_IDLE, 0, "short_mismatch_idle");
    wait_cyc(e + 4);
    force_en = 1'b0;
    wait_cyc(e + 15);
    enable = 1'b0;
    wait_cyc(e + 16);

    // Clamp: half_period=1 gives 5-cycle levels; async reset in RUN_LO
    half_period = 1; enable = 1'b1;
    e = cyc + 1;
    for (int k = 0; k < 15; k++)
      expect_at(e + k, ((k / 5) % 2 == 0) ? P_HI : P_LO, k / 5 + 1, "clamp_run");
    wait_cyc(e + 17);
    check_now("pre_reset_run_lo", {P_LO, CNT_W'(4)});
    #1;
    aresetn = 1'b0;
    #1;
    check_now("async_reset_release", {P_IDLE, CNT_W'(0)});
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    expect_at(cyc, P_IDLE, 0, "post_reset_idle");
    expect_at(cyc + 1, P_HI, 1, "post_reset_run_hi");
    wait_cyc(cyc + 2);
    enable = 1'b0;

    budget = 0;
    while (exp_cyc_q.size() > 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    if (exp_cyc_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain %0d expectations left unchecked", exp_cyc_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
